// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order requests to instruction memory and fills the IF/ID
// register through a small fetch queue that absorbs decode stalls and memory latency.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ID_stall,
  input  logic        ID_PCSrc,
  input  logic [31:0] ID_new_PC,
  output logic        IM_req_valid,
  output logic [31:0] IM_req_addr,
  input  logic        IM_req_ready,
  input  logic        IM_rsp_valid,
  input  logic [31:0] IM_rsp_data,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CRW = CW + 1;
  localparam logic [CRW-1:0] DepthW = CRW'(DEPTH);

  logic [31:0]   pc_q;
  logic          run_q;
  logic [AW-1:0] head_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] nfill_q;
  logic [CW-1:0] drop_q;
  logic [31:0]   pc4_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic           redirect;
  logic           accept;
  logic           head_filled;
  logic           rsp_drop;
  logic           rsp_take;
  logic           rsp_consumed;
  logic           pop_filled;
  logic           bypass;
  logic           pop;
  logic [CW-1:0]  unanswered;
  logic [CRW-1:0] credit;
  logic [AW-1:0]  tail_idx;
  logic [AW-1:0]  fill_idx;

  // Filled entries always sit at the head; unanswered ones follow them in request order.
  always_comb begin
    redirect     = ID_PCSrc & IF_ID_Valid & ~ID_stall;
    unanswered   = count_q - nfill_q;
    credit       = {1'b0, count_q} + {1'b0, drop_q};
    IM_req_valid = run_q & (credit < DepthW) & ~redirect;
    IM_req_addr  = pc_q;
    accept       = IM_req_valid & IM_req_ready;
    head_filled  = (nfill_q != '0);
    rsp_drop     = IM_rsp_valid & (drop_q != '0);
    rsp_take     = IM_rsp_valid & (drop_q == '0) & (unanswered != '0);
    rsp_consumed = rsp_drop | rsp_take;
    pop_filled   = ~ID_stall & ~redirect & head_filled;
    bypass       = ~ID_stall & ~redirect & ~head_filled & rsp_take;
    pop          = pop_filled | bypass;
    tail_idx     = head_q + count_q[AW-1:0];
    fill_idx     = head_q + nfill_q[AW-1:0];
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      pc4_mem[tail_idx] <= pc_q + 32'd4;
    end
    if (rsp_take && !bypass) begin
      data_mem[fill_idx] <= IM_rsp_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q              <= RESET_PC;
      run_q             <= 1'b0;
      head_q            <= '0;
      count_q           <= '0;
      nfill_q           <= '0;
      drop_q            <= '0;
      IF_ID_Instruction <= '0;
      IF_ID_PC4         <= '0;
      IF_ID_Valid       <= 1'b0;
    end else begin
      // Holds off the first request for one cycle after reset release.
      run_q <= 1'b1;
      if (redirect) begin
        pc_q    <= ID_new_PC;
        count_q <= '0;
        nfill_q <= '0;
        // Every fetch still owed by memory becomes a drop, minus the one answering right now.
        drop_q  <= drop_q + unanswered - CW'(rsp_consumed);
      end else begin
        if (accept) begin
          pc_q <= pc_q + 32'd4;
        end
        if (pop) begin
          head_q <= head_q + AW'(1);
        end
        count_q <= count_q + CW'(accept) - CW'(pop);
        nfill_q <= nfill_q + CW'(rsp_take & ~bypass) - CW'(pop_filled);
        drop_q  <= drop_q - CW'(rsp_drop);
      end

      if (!ID_stall) begin
        if (pop_filled) begin
          IF_ID_Instruction <= data_mem[head_q];
          IF_ID_PC4         <= pc4_mem[head_q];
          IF_ID_Valid       <= 1'b1;
        end else if (bypass) begin
          IF_ID_Instruction <= IM_rsp_data;
          IF_ID_PC4         <= pc4_mem[head_q];
          IF_ID_Valid       <= 1'b1;
        end else begin
          IF_ID_Instruction <= '0;
          IF_ID_PC4         <= '0;
          IF_ID_Valid       <= 1'b0;
        end
      end
    end
  end

endmodule
